// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared constants, types and the round-robin search function for the
// handshake arbiter and future schedulers built on the same picker.
package handshake_arb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int DATA_W_DEF  = 5;
    localparam int MAX_REQ     = 8;
    localparam int SRC_W       = $clog2(NUM_REQ_DEF);

    typedef logic [SRC_W-1:0] src_t;

    typedef struct packed {
        logic       any;
        logic [2:0] idx;
    } rr_res_t;

    // Scan last+1, last+2, ... modulo n; last < n so one conditional
    // subtraction replaces the modulo.
    function automatic rr_res_t next_rr(input logic [MAX_REQ-1:0] valid,
                                        input logic [2:0]         last,
                                        input int                 n);
        rr_res_t r;
        int      k;
        r = '0;
        for (int off = 1; off <= MAX_REQ; off++) begin
            k = int'(last) + off;
            if (k >= n) k = k - n;
            if (off <= n && !r.any && valid[k[2:0]]) begin
                r.any = 1'b1;
                r.idx = k[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/handshake_rr_arbiter_if.sv
// Ready/valid bundle between NUM_REQ requesters, the arbiter and the
// downstream port. slave = arbiter side, master = requester/sink side.
interface handshake_rr_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 5,
    parameter int SRC_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ-1:0]        in_ready;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Combinational round-robin priority picker: valid vector and last grant
// in, one-hot grant, index and any-valid flag out.
module rr_pick
    import handshake_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    rr_res_t res;

    always_comb begin
        res   = next_rr(MAX_REQ'(valid), 3'(last), NUM_REQ);
        any   = res.any;
        idx   = IDX_W'(res.idx);
        grant = '0;
        if (res.any) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry registered output stage.
// Define HANDSHAKE_ARB_STATS_EN to add saturating per-requester grant counters.
module handshake_rr_arbiter
    import handshake_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SRC_W   = $clog2(NUM_REQ),
    parameter int CNT_W   = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    handshake_rr_arbiter_if.slave     bus
`ifdef HANDSHAKE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  stat_grant_cnt
`endif
);
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SRC_W-1:0]  out_src_q,   out_src_d;
    logic [SRC_W-1:0]  last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   win_idx;
    logic               win_any;
    logic               can_load;
    logic               load;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(SRC_W)) u_pick (
        .valid (bus.in_valid),
        .last  (last_grant_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        can_load     = !out_valid_q || bus.out_ready;
        load         = can_load && win_any;
        bus.in_ready = can_load ? grant : '0;

        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        // A load in the same cycle as a drain overwrites the old beat.
        if (load) begin
            out_valid_d  = 1'b1;
            out_data_d   = bus.in_data[win_idx*DATA_W +: DATA_W];
            out_src_d    = win_idx;
            last_grant_d = win_idx;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            last_grant_q <= SRC_W'(NUM_REQ-1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

`ifdef HANDSHAKE_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (load && win_idx == SRC_W'(i) && cnt_q[i] != '1)
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign stat_grant_cnt = cnt_q;
`endif
endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
- Shares one ready/valid datapath stage among NUM_REQ ready/valid requesters, using round-robin arbitration.
- The winning requester's payload is captured into a one-entry output register, tagged with its source index.
- Sits in front of the foo_RTL handshake port, with the handshake_arr requesters as its inputs.
- Provides registered output, full throughput and starvation-free fairness.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 5, payload width per requester.
- SRC_W, $clog2(NUM_REQ), width of the source tag.
- CNT_W, 8, width of each grant counter (optional feature only).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  NUM_REQ  per-requester valid.
- in_ready  output  NUM_REQ  per-requester ready; one-hot or zero.
- in_data  input  NUM_REQ*DATA_W  packed payloads; requester i occupies [i*DATA_W +: DATA_W].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  registered payload.
- out_src  output  SRC_W  index of the requester that produced out_data.
- stat_grant_cnt  output  NUM_REQ*CNT_W  per-requester grant counters; present only with HANDSHAKE_ARB_STATS_EN.

Behaviour:
- Reset (RESET=1 at posedge): out_valid=0, out_data=0, out_src=0, last_grant=NUM_REQ-1 (so requester 0 wins first). RESET overrides any in-flight handshake; a beat held at reset is dropped.
- can_load = !out_valid || out_ready (register empty, or being drained this cycle).
- Winner selection: the first i with in_valid[i]=1, scanning last_grant+1, last_grant+2, ... modulo NUM_REQ; wrap-around is required.
- in_ready[winner] = can_load; all other in_ready bits = 0. in_ready is combinational from in_valid, out_valid, out_ready and last_grant. No in_ready bit is asserted when no in_valid is set.
- Load on posedge when can_load and any in_valid is set: out_data <= winner's payload, out_src <= winner, out_valid <= 1, last_grant <= winner.
- Drain with no new beat: out_valid && out_ready with no in_valid gives out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous drain and load: the new beat replaces the old one in the same cycle, giving no bubble and 1 beat per cycle sustained.
- Stall: out_valid && !out_ready means all in_ready=0. out_data, out_src and last_grant are held stable.
- Latency: exactly 1 cycle from input handshake to out_valid.
- Fairness: with all requesters continuously valid, the grant sequence is 0,1,2,0,1,2,...
- A requester that drops valid before being granted loses nothing; there is no grant lock across cycles.
- last_grant changes only on a completed input handshake.

Optional Feature:
- Macro: HANDSHAKE_ARB_STATS_EN.
- When defined:
  - Adds one CNT_W saturating counter per requester, exposed on stat_grant_cnt.
  - Counter i increments on each completed input handshake of requester i and saturates at all-ones.
  - Counters reset to 0 on RESET.
- When undefined: the stat_grant_cnt port and all counter logic are absent; all other behaviour is identical.

Decomposition:
- Package handshake_arb_pkg holds:
  - default constants NUM_REQ_DEF=3, DATA_W_DEF=5;
  - typedef src_t (logic [SRC_W-1:0]);
  - function next_rr(valid, last) returning the winner index and an any-valid flag.
- Sub-module rr_pick: purely combinational round-robin priority picker (valid vector + last_grant -> onehot grant, index, any). It is reused by future schedulers.
- The output register, pointer and stats counters stay in the top-level module.

Test Plan:
1. Reset then idle: hold RESET for 2 cycles, all in_valid=0 -> out_valid=0, out_data=0, out_src=0, in_ready=000 on every cycle.
2. Single requester: in_valid=010, in_data[1]=5'h15, out_ready=1 -> in_ready=010 in the same cycle; next cycle out_valid=1, out_data=5'h15, out_src=1.
3. Round-robin: in_valid=111 held for 6 cycles with out_ready=1 -> out_src sequence 0,1,2,0,1,2 with out_valid continuously 1 after the first load.
4. Backpressure: load a beat, then out_ready=0 for 3 cycles with in_valid=111 -> in_ready=000 and out_data/out_src stable; on release the next grant follows last_grant.
5. Wrap and gaps: last_grant=2, in_valid=101 -> requester 0 wins; next cycle requester 2 wins.
6. Stats (HANDSHAKE_ARB_STATS_EN, CNT_W=2): give requester 0 five grants -> its counter reads 1,2,3,3,3; RESET clears it to 0. Reset mid-stall drops the held beat: out_valid=0 next cycle.
